// File: rtl/save_results_nch.sv
`default_nettype none
// ============================================================================
// Module   : save_results_nch
// Purpose  : Parametrised result writer. Snapshots NUM_CH displacement words
//            when the correlation core flags a result, then writes them one
//            per WRITE cycle into the result BRAM port, separated by a
//            WAIT_CYCLES settle gap. Tracks the record count, flags overrun
//            and overflow, and raises the PS done words on gamma_done.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock         in   rising-edge clock
//   reset         in   synchronous active-high reset
//   results_done  in   record ready on dis_flat (level or pulse)
//   gamma_done    in   frame complete (level)
//   dis_flat      in   NUM_CH*DATA_W, channel c at [c*DATA_W +: DATA_W]
//   addr          out  BRAM byte address
//   we            out  BRAM byte write enables
//   ea            out  BRAM enable
//   din           out  BRAM write data
//   busy          out  record write in progress
//   record_count  out  completed records
//   overrun       out  sticky: new results_done while busy
//   overflow      out  sticky: results_done at capacity
//   result_done   out  bit0 = frame done
//   Save_Done     out  copy of result_done
// ============================================================================
module save_results_nch #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter int                NUM_CH      = 3,
  parameter int                WAIT_CYCLES = 3,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                STRIDE      = 4,
  parameter int                MAX_RECORDS = 1024,
  localparam int               RC_W        = $clog2(MAX_RECORDS + 1)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     results_done,
  input  logic                     gamma_done,
  input  logic [NUM_CH*DATA_W-1:0] dis_flat,
  output logic [ADDR_W-1:0]        addr,
  output logic [DATA_W/8-1:0]      we,
  output logic                     ea,
  output logic [DATA_W-1:0]        din,
  output logic                     busy,
  output logic [RC_W-1:0]          record_count,
  output logic                     overrun,
  output logic                     overflow,
  output logic [31:0]              result_done,
  output logic [31:0]              Save_Done
);

  localparam int                CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [3:0]        GAP_LAST = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic [RC_W-1:0]   MAX_RC   = RC_W'(MAX_RECORDS);
  localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(STRIDE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [DATA_W-1:0]   snap [NUM_CH];
  logic [CH_W-1:0]     ch;
  logic [CH_W-1:0]     ch_nxt;
  logic [3:0]          gap_cnt;
  logic [ADDR_W-1:0]   ptr;        // address of the next word to be written
  logic                rd_prev;

  logic                has_room;
  logic                accept;
  logic                advance;    // current channel finished its write + gap
  logic                last_ch;
  logic                next_write;
  logic                record_end;

  assign has_room   = (record_count < MAX_RC);
  assign accept     = (state == S_IDLE) && results_done && has_room;
  assign last_ch    = (ch == LAST_CH);
  assign ch_nxt     = ch + 1'b1;
  assign advance    = ((state == S_WRITE) && (WAIT_CYCLES == 0)) ||
                      ((state == S_GAP) && (gap_cnt == GAP_LAST));
  assign next_write = advance && !last_ch;
  assign record_end = advance && last_ch;

  assign busy        = (state == S_WRITE) || (state == S_GAP);
  assign we          = {(DATA_W/8){state == S_WRITE}};
  assign result_done = {31'b0, state == S_DONE};
  assign Save_Done   = result_done;

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        // A pending record wins over gamma_done; gamma_done is looked at again
        // on the next IDLE cycle.
        if (results_done) begin
          if (has_room) state_nxt = S_WRITE;
        end else if (gamma_done) begin
          state_nxt = S_DONE;
        end
      end
      S_WRITE: begin
        if (WAIT_CYCLES > 0) state_nxt = S_GAP;
        else if (last_ch)    state_nxt = S_IDLE;
        else                 state_nxt = S_WRITE;
      end
      S_GAP: begin
        if (advance) state_nxt = last_ch ? S_IDLE : S_WRITE;
      end
      S_DONE: begin
        if (!gamma_done) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Datapath: address/data are loaded on the edge that enters WRITE so they
  // are valid together with we, and simply hold through GAP.
  always_ff @(posedge clock) begin
    if (reset) begin
      addr         <= BASE_ADDR;
      ptr          <= BASE_ADDR;
      din          <= '0;
      ea           <= 1'b0;
      ch           <= '0;
      gap_cnt      <= '0;
      record_count <= '0;
      overrun      <= 1'b0;
      overflow     <= 1'b0;
      rd_prev      <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) snap[c] <= '0;
    end else begin
      ea      <= 1'b1;
      rd_prev <= results_done;

      if (accept) begin
        for (int c = 0; c < NUM_CH; c++) snap[c] <= dis_flat[c*DATA_W +: DATA_W];
        ch   <= '0;
        addr <= ptr;
        ptr  <= ptr + STRIDE_A;
        din  <= dis_flat[DATA_W-1:0];
      end

      if ((state == S_IDLE) && results_done && !has_room) overflow <= 1'b1;

      // Only a fresh assertion counts as an overrun, so a held-high
      // results_done chaining back-to-back records is not flagged.
      if (busy && results_done && !rd_prev) overrun <= 1'b1;

      if (state == S_WRITE)    gap_cnt <= '0;
      else if (state == S_GAP) gap_cnt <= gap_cnt + 1'b1;

      if (next_write) begin
        ch   <= ch_nxt;
        addr <= ptr;
        ptr  <= ptr + STRIDE_A;
        din  <= snap[ch_nxt];
      end

      if (record_end) record_count <= record_count + 1'b1;

      // Leaving DONE re-arms the writer for the next frame.
      if ((state == S_DONE) && !gamma_done) begin
        record_count <= '0;
        ptr          <= BASE_ADDR;
        addr         <= BASE_ADDR;
        overflow     <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_save_results_nch.sv
`default_nettype none
// ============================================================================
// Module   : tb_save_results_nch
// Purpose  : Self-checking bench for save_results_nch (NUM_CH=3,
//            WAIT_CYCLES=3, MAX_RECORDS=2). Expected BRAM writes are queued
//            by the stimulus; a negedge monitor pops and compares each one.
// Revision : 1.0 - initial release
// ============================================================================
module tb_save_results_nch;

  localparam int RC_W = $clog2(2 + 1);

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          results_done = 1'b0;
  logic          gamma_done = 1'b0;
  logic [95:0]   dis_flat = '0;
  logic [31:0]   addr;
  logic [3:0]    we;
  logic          ea;
  logic [31:0]   din;
  logic          busy;
  logic [RC_W-1:0] record_count;
  logic          overrun;
  logic          overflow;
  logic [31:0]   result_done;
  logic [31:0]   Save_Done;

  save_results_nch #(
    .DATA_W(32), .ADDR_W(32), .NUM_CH(3), .WAIT_CYCLES(3),
    .BASE_ADDR(32'h0), .STRIDE(4), .MAX_RECORDS(2)
  ) dut (
    .clock(clock), .reset(reset), .results_done(results_done),
    .gamma_done(gamma_done), .dis_flat(dis_flat), .addr(addr), .we(we),
    .ea(ea), .din(din), .busy(busy), .record_count(record_count),
    .overrun(overrun), .overflow(overflow), .result_done(result_done),
    .Save_Done(Save_Done)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  vectors = 0;
  int  miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Queue n writes of a record accepted in cycle acc, first word index base.
  task automatic push_rec(input int base, input logic [95:0] d, input int acc, input int n);
    for (int i = 0; i < n; i++) begin
      wr_t e;
      e.cyc = acc + 1 + 4*i;
      e.a   = 32'((base + i) * 4);
      e.d   = d[i*32 +: 32];
      exp_q.push_back(e);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_addr", addr, 32'h0);
    chk("rst_we", {28'h0, we}, 32'h0);
    chk("rst_ea", {31'h0, ea}, 32'h0);
    chk("rst_din", din, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_count", 32'(record_count), 32'h0);
    chk("rst_overrun", {31'h0, overrun}, 32'h0);
    chk("rst_overflow", {31'h0, overflow}, 32'h0);
    chk("rst_result_done", result_done, 32'h0);
    chk("rst_save_done", Save_Done, 32'h0);
  endtask

  // Monitor: every write strobe must match the head of the expected queue.
  always @(negedge clock) begin
    if (!reset && we !== 4'h0) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: addr=%0h din=%0h cycle %0d, none expected", addr, din, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_we", {28'h0, we}, 32'hF);
        chk("wr_addr", addr, mon_e.a);
        chk("wr_din", din, mon_e.d);
        chk("wr_cycle", cyc, mon_e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    tick(3);
    chk_reset_vals();
    reset = 1'b0;
    tick();
    chk("ea_after_reset", {31'h0, ea}, 32'h1);

    // Two records back-to-back with results_done held high.
    c0 = cyc;
    dis_flat = {32'h33, 32'h22, 32'h11};
    results_done = 1'b1;
    push_rec(0, {32'h33, 32'h22, 32'h11}, c0, 3);
    push_rec(3, {32'h66, 32'h55, 32'h44}, c0 + 13, 3);
    tick();
    chk("busy_rec1", {31'h0, busy}, 32'h1);
    dis_flat = {32'hDEAD, 32'hBEEF, 32'hF00D};   // snapshot makes this don't-care
    tick(4);
    dis_flat = {32'h66, 32'h55, 32'h44};
    tick(8);
    chk("count_rec1", 32'(record_count), 32'h1);
    chk("idle_between", {31'h0, busy}, 32'h0);
    tick();
    results_done = 1'b0;
    tick(12);
    chk("count_rec2", 32'(record_count), 32'h2);
    chk("busy_rec2_end", {31'h0, busy}, 32'h0);
    chk("overrun_held", {31'h0, overrun}, 32'h0);

    // Third record at capacity: overflow, no write.
    results_done = 1'b1;
    tick();
    results_done = 1'b0;
    chk("overflow_set", {31'h0, overflow}, 32'h1);
    chk("count_cap", 32'(record_count), 32'h2);
    chk("busy_cap", {31'h0, busy}, 32'h0);
    tick(3);

    // Frame done handshake.
    gamma_done = 1'b1;
    tick();
    chk("result_done_set", result_done, 32'h1);
    chk("save_done_set", Save_Done, 32'h1);
    tick();
    gamma_done = 1'b0;
    tick();
    chk("result_done_clr", result_done, 32'h0);
    chk("save_done_clr", Save_Done, 32'h0);
    chk("count_clr", 32'(record_count), 32'h0);
    chk("overflow_clr", {31'h0, overflow}, 32'h0);
    chk("addr_clr", addr, 32'h0);

    // Fresh record from address 0, with a results_done pulse during GAP.
    c0 = cyc;
    dis_flat = {32'hA3, 32'hA2, 32'hA1};
    results_done = 1'b1;
    push_rec(0, {32'hA3, 32'hA2, 32'hA1}, c0, 3);
    tick();
    results_done = 1'b0;
    tick(2);
    results_done = 1'b1;
    tick();
    results_done = 1'b0;
    tick();
    chk("overrun_set", {31'h0, overrun}, 32'h1);
    tick(8);
    chk("count_after_overrun", 32'(record_count), 32'h1);
    chk("busy_after_overrun", {31'h0, busy}, 32'h0);

    // Reset in the cycle after the second WRITE of a record.
    c0 = cyc;
    dis_flat = {32'hB3, 32'hB2, 32'hB1};
    results_done = 1'b1;
    push_rec(3, {32'hB3, 32'hB2, 32'hB1}, c0, 2);
    tick();
    results_done = 1'b0;
    tick(5);
    reset = 1'b1;
    tick();
    chk_reset_vals();
    reset = 1'b0;
    tick(20);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
